// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the digit-serial BCD add/subtract sequencer.
// FIX exists in the state enum only when BCD_NEG_FIXUP_EN is defined.
package bcd_seq_pkg;

   localparam logic       OP_ADD        = 1'b0;
   localparam logic       OP_SUB        = 1'b1;
   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

`ifdef BCD_NEG_FIXUP_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd3
   } state_e;
`endif

endpackage

// File: rtl/bcd_addsub_sequencer_digit_add.sv
// Single BCD digit adder: binary sum with +6 decimal correction above 9.
module bcd_digit_add (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] bin;

   always_comb begin
      bin  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      cout = (bin > 5'd9);
      // The +6 wraps modulo 16, leaving the corrected decimal digit.
      sum  = cout ? (bin[3:0] + 4'd6) : bin[3:0];
   end

endmodule

// File: rtl/bcd_addsub_sequencer.sv
// Digit-serial BCD add/subtract, LSB digit first, through one shared bcd_digit_add.
// Define BCD_NEG_FIXUP_EN to convert negative differences to their magnitude in a FIX pass.
module bcd_addsub_sequencer
   import bcd_seq_pkg::*;
#(
   parameter int NDIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 op,
   input  logic [4*NDIGITS-1:0] a,
   input  logic [4*NDIGITS-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [4*NDIGITS-1:0] result,
   output logic                 neg,
   output logic                 ovf,
   output logic                 err,
   output state_e               state_o
);

   localparam int W  = 4*NDIGITS;
   localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIGITS-1);

   state_e        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          c_q, c_d, op_q, op_d, neg_q, neg_d, ovf_q, ovf_d, err_q, err_d;

   logic          bad_digit, in_fix, dig_cout;
   logic [3:0]    dig_a, dig_b, dig_sum;
   logic [W-1:0]  shifted;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         if ((a[4*i +: 4] > BCD_MAX_DIGIT) || (b[4*i +: 4] > BCD_MAX_DIGIT)) bad_digit = 1'b1;
      end
   end

`ifdef BCD_NEG_FIXUP_EN
   assign in_fix = (state_q == FIX);
`else
   assign in_fix = 1'b0;
`endif

   // FIX reuses the adder as (9 - r_i) + 0 + carry; subtract feeds the nine's complement of b.
   always_comb begin
      dig_a = in_fix ? (BCD_MAX_DIGIT - acc_q[3:0]) : a_q[3:0];
      dig_b = in_fix ? 4'd0 :
              ((op_q == OP_SUB) ? (BCD_MAX_DIGIT - b_q[3:0]) : b_q[3:0]);
   end

   bcd_digit_add u_digit_add (
      .a    (dig_a),
      .b    (dig_b),
      .cin  (c_q),
      .sum  (dig_sum),
      .cout (dig_cout)
   );

   assign shifted = W'({dig_sum, acc_q} >> 4);

   // start is a request sampled only in IDLE; busy high means it is ignored, done pulses once.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      op_d    = op_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               acc_d   = '0;
               res_d   = '0;
               cnt_d   = '0;
               c_d     = (op == OP_SUB);
               neg_d   = 1'b0;
               ovf_d   = 1'b0;
               err_d   = bad_digit;
               state_d = bad_digit ? DONE : ADD;
            end
         end
         ADD: begin
            a_d   = a_q >> 4;
            b_d   = b_q >> 4;
            acc_d = shifted;
            c_d   = dig_cout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
               res_d   = shifted;
               ovf_d   = (op_q == OP_ADD) && dig_cout;
               neg_d   = (op_q == OP_SUB) && !dig_cout;
`ifdef BCD_NEG_FIXUP_EN
               if ((op_q == OP_SUB) && !dig_cout) begin
                  c_d     = 1'b1;
                  state_d = FIX;
                  res_d   = res_q;
                  neg_d   = 1'b0;
               end
`endif
            end
         end
`ifdef BCD_NEG_FIXUP_EN
         FIX: begin
            acc_d = shifted;
            c_d   = dig_cout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
               res_d   = shifted;
               neg_d   = 1'b1;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         op_q    <= 1'b0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign result  = res_q;
   assign neg     = neg_q;
   assign ovf     = ovf_q;
   assign err     = err_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_bcd_addsub_sequencer.sv
// Directed bench for bcd_addsub_sequencer: hand-computed vectors, cycle-accurate done timing.
// Expectations for negative differences follow BCD_NEG_FIXUP_EN.
module tb_bcd_addsub_sequencer;
   import bcd_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, start, op;
   logic [15:0] a, b, result;
   logic        busy, done, neg, ovf, err;
   state_e      state_o;

   int n_checks = 0;
   int n_errors = 0;

`ifdef BCD_NEG_FIXUP_EN
   localparam int          NEG_DONE = 9;
   localparam logic [15:0] NEG_RES  = 16'h0073;
`else
   localparam int          NEG_DONE = 5;
   localparam logic [15:0] NEG_RES  = 16'h9927;
`endif

   bcd_addsub_sequencer #(.NDIGITS(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .neg     (neg),
      .ovf     (ovf),
      .err     (err),
      .state_o (state_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycle 0 is the start-high cycle; outputs are sampled on falling edges.
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic opv, input logic [15:0] er, input logic en,
                         input logic eo, input logic ee, input int edc, input int poke);
      int done_cyc;
      @(negedge clk);
      a = av; b = bv; op = opv; start = 1'b1;
      done_cyc = -1;
      for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         start = (cyc == poke);
         if (cyc == 1) begin
            a = 16'hFFFF; b = 16'hFFFF; op = ~opv;
            if (edc != 1) check_eq({tag, ":err_cleared"}, 32'(err), 32'(0));
         end
         if (done === 1'b1) done_cyc = cyc;
         else check_eq({tag, ":busy"}, 32'(busy), 32'(1));
      end
      check_eq({tag, ":done_cycle"}, 32'(done_cyc), 32'(edc));
      check_eq({tag, ":busy_in_done"}, 32'(busy), 32'(1));
      check_eq({tag, ":result"}, 32'(result), 32'(er));
      check_eq({tag, ":neg"}, 32'(neg), 32'(en));
      check_eq({tag, ":ovf"}, 32'(ovf), 32'(eo));
      check_eq({tag, ":err"}, 32'(err), 32'(ee));
      @(negedge clk);
      start = 1'b0;
      check_eq({tag, ":done_pulse_end"}, 32'(done), 32'(0));
      check_eq({tag, ":idle_after"}, 32'(busy), 32'(0));
      check_eq({tag, ":result_held"}, 32'(result), 32'(er));
      @(negedge clk);
      check_eq({tag, ":not_restarted"}, 32'(busy), 32'(0));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check_eq("reset:busy",   32'(busy),    32'(0));
      check_eq("reset:done",   32'(done),    32'(0));
      check_eq("reset:result", 32'(result),  32'(0));
      check_eq("reset:flags",  32'({neg, ovf, err}), 32'(0));
      check_eq("reset:state",  32'(state_o), 32'(IDLE));
      rst_n = 1'b1;

      run_op("add",       16'h1234, 16'h5678, OP_ADD, 16'h6912, 1'b0, 1'b0, 1'b0, 5, 0);
      run_op("add_ovf",   16'h9999, 16'h0001, OP_ADD, 16'h0000, 1'b0, 1'b1, 1'b0, 5, 0);
      run_op("sub_neg",   16'h0050, 16'h0123, OP_SUB, NEG_RES,  1'b1, 1'b0, 1'b0, NEG_DONE, 0);
      run_op("sub_pos",   16'h0500, 16'h0123, OP_SUB, 16'h0377, 1'b0, 1'b0, 1'b0, 5, 0);
      run_op("bad_digit", 16'h12A4, 16'h0001, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 0);
      run_op("after_err", 16'h0100, 16'h0200, OP_ADD, 16'h0300, 1'b0, 1'b0, 1'b0, 5, 0);
      run_op("sub_zero",  16'h0123, 16'h0123, OP_SUB, 16'h0000, 1'b0, 1'b0, 1'b0, 5, 0);
      run_op("poke_busy", 16'h2000, 16'h3000, OP_ADD, 16'h5000, 1'b0, 1'b0, 1'b0, 5, 2);
      run_op("poke_done", 16'h0999, 16'h0001, OP_ADD, 16'h1000, 1'b0, 1'b0, 1'b0, 5, 5);

      // Start in cycle 0, ignored start in cycle 2, reset asserted in cycle 3.
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; op = OP_ADD; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("abort:c1_done", 32'(done), 32'(0));
      @(negedge clk);
      start = 1'b1; a = 16'h4444;
      check_eq("abort:c2_done", 32'(done), 32'(0));
      @(negedge clk);
      start = 1'b0; rst_n = 1'b0;
      check_eq("abort:c3_done", 32'(done), 32'(0));
      @(negedge clk);
      check_eq("abort:busy",   32'(busy),    32'(0));
      check_eq("abort:done",   32'(done),    32'(0));
      check_eq("abort:result", 32'(result),  32'(0));
      check_eq("abort:flags",  32'({neg, ovf, err}), 32'(0));
      check_eq("abort:state",  32'(state_o), 32'(IDLE));
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check_eq("abort:no_done", 32'(done), 32'(0));
      end

      run_op("recover", 16'h0500, 16'h0123, OP_SUB, 16'h0377, 1'b0, 1'b0, 1'b0, 5, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bcd_addsub_sequencer.md
BCD_ADDSUB_SEQUENCER -- requirements
Module: bcd_addsub_sequencer

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, giving the number of BCD digits per operand and result.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 1, operation select: 0 = A+B, 1 = A-B.
REQ-006 SHALL have ports a and b, input, 4*NDIGITS, packed BCD operands with the least significant digit in [3:0].
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port result, output, 4*NDIGITS, packed BCD result.
REQ-010 SHALL have ports neg, ovf and err, output, 1 each: negative result, addition overflow, and invalid input digit.

Function
REQ-011 SHALL implement states IDLE, ADD, FIX, DONE.
REQ-012 SHALL accept start only in IDLE; on acceptance SHALL latch a, b and op and SHALL ignore input changes until the next acceptance.
REQ-013 SHALL check all latched digits at acceptance; if any digit exceeds 9, SHALL go IDLE->DONE with err=1, result=0, neg=0, ovf=0.
REQ-014 SHALL otherwise go to ADD and process one digit per cycle, LSB first, for NDIGITS cycles, through a single digit adder.
REQ-015 SHALL, in ADD, use a_i + b_i for add and a_i + (9 - b_i) for subtract; carry-in to digit 0 SHALL be 0 for add and 1 for subtract.
REQ-016 SHALL on add set ovf to the final digit carry; result SHALL be the low NDIGITS digits (wrap-around).
REQ-017 SHALL on subtract set ovf=0 and neg to the inverse of the final carry.
REQ-018 SHALL, when neg=1 and fix-up is compiled in, run FIX for NDIGITS cycles, replacing each result digit with (9 - r_i) plus carry, initial carry 1, giving the magnitude.
REQ-019 SHALL spend exactly one cycle in DONE with done=1, then return to IDLE.
REQ-020 SHALL time operations from a start-high cycle numbered 0: done high in cycle NDIGITS+1 (no FIX), 2*NDIGITS+1 (with FIX), or 1 (err).
REQ-021 SHALL hold result, neg, ovf and err from DONE until the next accepted start, then clear them.
REQ-022 SHALL ignore start while busy, including in DONE; no queuing.
REQ-023 SHALL report the result 0 from any subtract as neg=0, for example 0123-0123 = 0000.

Reset
REQ-024 SHALL on rst_n=0 at a clock edge go to IDLE and drive busy=0, done=0, result=0, neg=0, ovf=0, err=0.
REQ-025 SHALL abort any operation in progress when reset is applied, with no done pulse.

Configuration
REQ-026 SHALL honour macro BCD_NEG_FIXUP_EN.
- Defined: FIX state present, behaving as in REQ-018.
- Undefined: no FIX state; a negative subtract returns the ten's-complement result with neg=1, done in cycle NDIGITS+1.

Structure
REQ-027 SHALL place the following in shared package bcd_seq_pkg: the state enum, op encodings OP_ADD=0 and OP_SUB=1, and constant BCD_MAX_DIGIT=9.
REQ-028 SHALL instantiate one combinational sub-module, bcd_digit_add: 4-bit a, 4-bit b and cin in; 4-bit sum and cout out; with +6 decimal correction when the binary sum exceeds 9.
REQ-029 SHALL use a digit-index counter and shift or indexed registers, not a parallel NDIGITS-wide adder.

Verification
REQ-030 SHALL verify add: 1234+5678 -> result 6912, ovf=0, neg=0, done in cycle 5, busy in cycles 1-5.
REQ-031 SHALL verify add overflow: 9999+0001 -> result 0000, ovf=1.
REQ-032 SHALL verify negative subtract: 0050-0123 -> with macro, result 0073, neg=1, done in cycle 9; without macro, result 9927, neg=1, done in cycle 5.
REQ-033 SHALL verify invalid input: a=12A4 -> err=1, result 0000, done in cycle 1; next valid start clears err.
REQ-034 SHALL verify ignored start and reset: start pulsed in cycle 2 is ignored; rst_n low in cycle 3 -> no done, all outputs 0 next cycle, IDLE.
REQ-035 SHALL verify zero difference: 0123-0123 -> result 0000, neg=0, done in cycle 5.
